// File: rtl/debug_port_responder_if.sv
// CPU-side bundle of the debug responder: halt handshake plus the three read ports.
// Latency: none (wires only); the responder registers everything it drives.
// Backpressure: none; halt_ack is a level handshake and the read ports have fixed latency.
//
// master: the responder (drives halt_req, port_owner, read addresses; samples halt_ack and read data)
// slave : the CPU core / memory wrapper
interface debug_port_responder_if #(
    parameter int DATA_W   = 8,
    parameter int D_ADDR_W = 12,
    parameter int INST_W   = 16,
    parameter int I_ADDR_W = 12
) ();
    logic                halt_req;
    logic                halt_ack;
    logic                port_owner;
    logic [I_ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0]   imem_rdata;
    logic [D_ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0]   dmem_rdata;
    logic [3:0]          reg_addr;
    logic [DATA_W-1:0]   reg_rdata;

    modport master (
        output halt_req, port_owner, imem_addr, dmem_addr, reg_addr,
        input  halt_ack, imem_rdata, dmem_rdata, reg_rdata
    );

    modport slave (
        input  halt_req, port_owner, imem_addr, dmem_addr, reg_addr,
        output halt_ack, imem_rdata, dmem_rdata, reg_rdata
    );
endinterface

// File: rtl/debug_port_responder.sv
// Debug read responder: halts the core, owns the read ports, sweeps imem/dmem/regfile into hold registers.
// Latency: one item every RD_LAT+1 cycles, full sweep 3*(RD_LAT+1); halt_req/port_owner are registered.
// Backpressure: none; a halt_ack timeout parks the block in BLOCKED until debug_enable drops.
//
// Ports: clk, reset_n (async, active low); debug_enable and the three *_debug_addr from the board side;
// *_debug_rdata hold registers and sticky halt_timeout back to the board; cpu = halt handshake + read ports.
module debug_port_responder #(
    parameter int DATA_W       = 8,
    parameter int D_ADDR_W     = 12,
    parameter int INST_W       = 16,
    parameter int I_ADDR_W     = 12,
    parameter int RD_LAT       = 1,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                debug_enable,
    input  logic [3:0]          reg_debug_addr,
    input  logic [D_ADDR_W-1:0] dmem_debug_addr,
    input  logic [I_ADDR_W-1:0] imem_debug_addr,
    output logic [DATA_W-1:0]   reg_debug_rdata,
    output logic [DATA_W-1:0]   dmem_debug_rdata,
    output logic [INST_W-1:0]   imem_debug_rdata,
    output logic                halt_timeout,
    debug_port_responder_if.master cpu
);
    // The timeout counter only ever holds 0..HALT_TIMEOUT-1.
    localparam int TO_W  = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT_WAIT,
        RD_IMEM,
        RD_DMEM,
        RD_REG,
        RELEASE,
        BLOCKED
    } state_t;

    state_t              state;
    logic [TO_W-1:0]     to_cnt;
    logic [LAT_W-1:0]    lat_cnt;
    logic                stop_pend;   // debug_enable dropped mid-item; leave after this capture
    logic                halt_req_q;
    logic                port_owner_q;
    logic [I_ADDR_W-1:0] imem_addr_q;
    logic [D_ADDR_W-1:0] dmem_addr_q;
    logic [3:0]          reg_addr_q;

    assign cpu.halt_req   = halt_req_q;
    assign cpu.port_owner = port_owner_q;
    assign cpu.imem_addr  = imem_addr_q;
    assign cpu.dmem_addr  = dmem_addr_q;
    assign cpu.reg_addr   = reg_addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            to_cnt           <= '0;
            lat_cnt          <= '0;
            stop_pend        <= 1'b0;
            halt_req_q       <= 1'b0;
            port_owner_q     <= 1'b0;
            imem_addr_q      <= '0;
            dmem_addr_q      <= '0;
            reg_addr_q       <= '0;
            imem_debug_rdata <= '0;
            dmem_debug_rdata <= '0;
            reg_debug_rdata  <= '0;
            halt_timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (debug_enable) begin
                        state        <= HALT_WAIT;
                        halt_req_q   <= 1'b1;
                        to_cnt       <= '0;
                        halt_timeout <= 1'b0;
                    end
                end

                HALT_WAIT: begin
                    // halt_ack outranks both an abandoned request and the timeout
                    if (cpu.halt_ack) begin
                        state        <= RD_IMEM;
                        port_owner_q <= 1'b1;
                        imem_addr_q  <= imem_debug_addr;
                        lat_cnt      <= '0;
                        stop_pend    <= 1'b0;
                    end else if (!debug_enable) begin
                        state      <= RELEASE;
                        halt_req_q <= 1'b0;
                    end else if (to_cnt == TO_W'(HALT_TIMEOUT - 1)) begin
                        state        <= BLOCKED;
                        halt_req_q   <= 1'b0;
                        halt_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                RD_IMEM, RD_DMEM, RD_REG: begin
                    if (!cpu.halt_ack) begin
                        // Core left halt under us: the read data cannot be trusted, drop it.
                        state        <= RELEASE;
                        halt_req_q   <= 1'b0;
                        port_owner_q <= 1'b0;
                        imem_addr_q  <= '0;
                        dmem_addr_q  <= '0;
                        reg_addr_q   <= '0;
                    end else if (lat_cnt == LAT_W'(RD_LAT)) begin
                        case (state)
                            RD_IMEM: imem_debug_rdata <= cpu.imem_rdata;
                            RD_DMEM: dmem_debug_rdata <= cpu.dmem_rdata;
                            default: reg_debug_rdata  <= cpu.reg_rdata;
                        endcase
                        if (stop_pend || !debug_enable) begin
                            state        <= RELEASE;
                            halt_req_q   <= 1'b0;
                            port_owner_q <= 1'b0;
                            imem_addr_q  <= '0;
                            dmem_addr_q  <= '0;
                            reg_addr_q   <= '0;
                        end else begin
                            // Address is sampled only on entry so mid-item changes wait a sweep.
                            lat_cnt <= '0;
                            case (state)
                                RD_IMEM: begin
                                    state       <= RD_DMEM;
                                    dmem_addr_q <= dmem_debug_addr;
                                end
                                RD_DMEM: begin
                                    state      <= RD_REG;
                                    reg_addr_q <= reg_debug_addr;
                                end
                                default: begin
                                    state       <= RD_IMEM;
                                    imem_addr_q <= imem_debug_addr;
                                end
                            endcase
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                        if (!debug_enable) begin
                            stop_pend <= 1'b1;
                        end
                    end
                end

                RELEASE: begin
                    state <= IDLE;
                end

                BLOCKED: begin
                    if (!debug_enable) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debug_port_responder.sv
// Bench for debug_port_responder: session-level reference model feeding a per-cycle scoreboard.
// Latency: expected outputs are queued one per cycle and checked on the falling edge.
// Backpressure: none; all stimulus timing is fixed, so every wait is a bounded cycle count.
module tb_debug_port_responder;
    localparam int DATA_W   = 8;
    localparam int D_ADDR_W = 12;
    localparam int INST_W   = 16;
    localparam int I_ADDR_W = 12;
    localparam int RD_LAT   = 1;
    localparam int HT       = 8;
    localparam int P        = RD_LAT + 1;   // cycles per item

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                debug_enable = 1'b0;
    logic                halt_ack = 1'b0;
    logic [3:0]          reg_debug_addr = '0;
    logic [D_ADDR_W-1:0] dmem_debug_addr = '0;
    logic [I_ADDR_W-1:0] imem_debug_addr = '0;
    logic [DATA_W-1:0]   reg_debug_rdata;
    logic [DATA_W-1:0]   dmem_debug_rdata;
    logic [INST_W-1:0]   imem_debug_rdata;
    logic                halt_timeout;

    debug_port_responder_if #(.DATA_W(DATA_W), .D_ADDR_W(D_ADDR_W), .INST_W(INST_W),
                              .I_ADDR_W(I_ADDR_W)) cpu ();

    debug_port_responder #(.DATA_W(DATA_W), .D_ADDR_W(D_ADDR_W), .INST_W(INST_W),
                           .I_ADDR_W(I_ADDR_W), .RD_LAT(RD_LAT), .HALT_TIMEOUT(HT)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .debug_enable     (debug_enable),
        .reg_debug_addr   (reg_debug_addr),
        .dmem_debug_addr  (dmem_debug_addr),
        .imem_debug_addr  (imem_debug_addr),
        .reg_debug_rdata  (reg_debug_rdata),
        .dmem_debug_rdata (dmem_debug_rdata),
        .imem_debug_rdata (imem_debug_rdata),
        .halt_timeout     (halt_timeout),
        .cpu              (cpu)
    );

    always #5 clk = ~clk;

    // Memories with RD_LAT-cycle synchronous read, as the wrapper presents them.
    logic [INST_W-1:0]   imem [4096];
    logic [DATA_W-1:0]   dmem [4096];
    logic [DATA_W-1:0]   regs [16];
    logic [I_ADDR_W-1:0] ia_pipe [RD_LAT];
    logic [D_ADDR_W-1:0] da_pipe [RD_LAT];
    logic [3:0]          ra_pipe [RD_LAT];

    always @(posedge clk) begin
        ia_pipe[0] <= cpu.imem_addr;
        da_pipe[0] <= cpu.dmem_addr;
        ra_pipe[0] <= cpu.reg_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            ia_pipe[i] <= ia_pipe[i-1];
            da_pipe[i] <= da_pipe[i-1];
            ra_pipe[i] <= ra_pipe[i-1];
        end
    end

    assign cpu.halt_ack   = halt_ack;
    assign cpu.imem_rdata = imem[ia_pipe[RD_LAT-1]];
    assign cpu.dmem_rdata = dmem[da_pipe[RD_LAT-1]];
    assign cpu.reg_rdata  = regs[ra_pipe[RD_LAT-1]];

    // Scoreboard entry: expected visible outputs for one cycle.
    // amode 0: all read addresses 0; 1/2/3: imem/dmem/reg address must equal aexp.
    typedef struct {
        logic              hr;
        logic              po;
        logic              to;
        int                amode;
        logic [15:0]       aexp;
        logic [INST_W-1:0] hi;
        logic [DATA_W-1:0] hd;
        logic [DATA_W-1:0] hg;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (written by the stimulus process only).
    logic [INST_W-1:0]   m_hi = '0;
    logic [DATA_W-1:0]   m_hd = '0;
    logic [DATA_W-1:0]   m_hg = '0;
    logic                m_to = 1'b0;
    logic [I_ADDR_W-1:0] lat_i = '0;
    logic [D_ADDR_W-1:0] lat_d = '0;
    logic [3:0]          lat_r = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, req);
        end
    endtask

    task automatic push(input logic hr, input logic po, input int amode, input int aval);
        exp_t e;
        e.hr = hr; e.po = po; e.to = m_to; e.amode = amode; e.aexp = aval[15:0];
        e.hi = m_hi; e.hd = m_hd; e.hg = m_hg;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_addr();
        imem_debug_addr = I_ADDR_W'($urandom_range(0, 63));
        dmem_debug_addr = D_ADDR_W'($urandom_range(0, 63));
        reg_debug_addr  = 4'($urandom_range(0, 15));
    endtask

    // One debug session, cycle 0 = first cycle debug_enable is high in IDLE.
    // kind 0: halt_ack at cycle a, debug_enable drops at owned cycle endp
    // kind 1: halt_ack at cycle a, halt_ack drops at owned cycle endp
    // kind 2: debug_enable drops at HALT_WAIT cycle endp, no ack
    // kind 3: no ack, timeout, debug_enable drops endp cycles into BLOCKED
    task automatic run_session(input int kind, input int a, input int endp,
                               input bit early_in, input bit directed);
        int o, rel, last, kd;
        bit early;
        early = (kind == 3) ? 1'b0 : early_in;
        o = a + 1;
        kd = 0;
        case (kind)
            0: begin kd = endp / P; rel = o + (kd + 1) * P; last = rel; end
            1: begin rel = o + endp + 1; last = rel; end
            2: begin rel = endp + 1; last = rel; o = 1 << 30; end
            default: begin rel = -1; last = HT + 1 + endp; o = 1 << 30; end
        endcase
        for (int c = 0; c <= last; c++) begin
            int  u;
            bit  own, de, ak;
            int  amode, aval;
            next_cycle();
            u = c - o;
            // A capture of item k shows up at owned cycle (k+1)*P if it completed.
            if (c >= o && u > 0 && (u % P) == 0) begin
                int k;
                k = u / P - 1;
                if ((kind == 0 && k <= kd) || (kind == 1 && u - 1 < endp)) begin
                    case (k % 3)
                        0:       m_hi = imem[lat_i];
                        1:       m_hd = dmem[lat_d];
                        default: m_hg = regs[lat_r];
                    endcase
                end
            end
            if (c == 1) m_to = 1'b0;
            if (kind == 3 && c == HT + 1) m_to = 1'b1;
            own   = (kind <= 1) && (c >= o) && (c < rel);
            amode = 0;
            aval  = 0;
            if (own) begin
                amode = (u / P) % 3 + 1;
                aval  = (amode == 1) ? int'(lat_i) : (amode == 2) ? int'(lat_d) : int'(lat_r);
            end
            push((c >= 1) && ((kind == 3) ? (c <= HT) : (c < rel)), own, amode, aval);
            // Inputs for this cycle.
            case (kind)
                0:       de = (c < o + endp) || (c == rel && early);
                1:       de = (c <= o + endp) || (c == rel && early);
                2:       de = (c < endp) || (c == rel && early);
                default: de = (c < last);
            endcase
            ak = (kind == 0) ? (c >= a && c < rel) :
                 (kind == 1) ? (c >= a && c < o + endp) : 1'b0;
            debug_enable = de;
            halt_ack     = ak;
            if (!directed) rand_addr();
            else if (u == 3 * P) dmem_debug_addr = D_ADDR_W'(12'h011);
            // Item j samples its address in the cycle before it starts.
            if (c >= o - 1 && ((c - o + 1) % P) == 0) begin
                case (((c - o + 1) / P) % 3)
                    0:       lat_i = imem_debug_addr;
                    1:       lat_d = dmem_debug_addr;
                    default: lat_r = reg_debug_addr;
                endcase
            end
        end
        if (!early) begin
            int g;
            g = $urandom_range(0, 2);
            for (int c = 0; c <= g; c++) begin
                next_cycle();
                push(1'b0, 1'b0, 0, 0);
                debug_enable = 1'b0;
                halt_ack     = 1'b0;
                if (!directed) rand_addr();
            end
        end
    endtask

    // Monitor: compare the DUT against the head of the queue every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_t e;
                bit   aok;
                e = exp_q.pop_front();
                case (e.amode)
                    0:       aok = (cpu.imem_addr == '0) && (cpu.dmem_addr == '0) && (cpu.reg_addr == '0);
                    1:       aok = (cpu.imem_addr == e.aexp[I_ADDR_W-1:0]);
                    2:       aok = (cpu.dmem_addr == e.aexp[D_ADDR_W-1:0]);
                    default: aok = (cpu.reg_addr == e.aexp[3:0]);
                endcase
                n_cmp++;
                if (!aok || cpu.halt_req !== e.hr || cpu.port_owner !== e.po || halt_timeout !== e.to ||
                    imem_debug_rdata !== e.hi || dmem_debug_rdata !== e.hd || reg_debug_rdata !== e.hg) begin
                    n_bad++;
                    $display("FAIL cycle_state at %0t: got hr=%0b po=%0b to=%0b ia=%h da=%h ra=%h hi=%h hd=%h hg=%h, required hr=%0b po=%0b to=%0b amode=%0d addr=%h hi=%h hd=%h hg=%h",
                             $time, cpu.halt_req, cpu.port_owner, halt_timeout, cpu.imem_addr, cpu.dmem_addr,
                             cpu.reg_addr, imem_debug_rdata, dmem_debug_rdata, reg_debug_rdata,
                             e.hr, e.po, e.to, e.amode, e.aexp, e.hi, e.hd, e.hg);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            imem[i] = INST_W'($urandom);
            dmem[i] = DATA_W'($urandom);
        end
        for (int i = 0; i < 16; i++) regs[i] = DATA_W'($urandom);
        imem[5]    = 16'hA55A;
        dmem[16]   = 8'h3C;
        dmem[17]   = 8'h99;
        regs[3]    = 8'h7E;

        // Reset, then reset again while sweeping the data memory.
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset_halt_req", 32'(cpu.halt_req), 32'h0);
        chk("reset_port_owner", 32'(cpu.port_owner), 32'h0);
        chk("reset_hold_imem", 32'(imem_debug_rdata), 32'h0);
        imem_debug_addr = 12'h005; dmem_debug_addr = 12'h010; reg_debug_addr = 4'd3;
        debug_enable = 1'b1;                 // cycle 0
        next_cycle();                        // cycle 1: HALT_WAIT
        chk("halt_req_rise", 32'(cpu.halt_req), 32'h1);
        halt_ack = 1'b1;
        next_cycle();                        // cycle 2: RD_IMEM
        next_cycle();                        // cycle 3
        next_cycle();                        // cycle 4: RD_DMEM
        chk("mid_sweep_owner", 32'(cpu.port_owner), 32'h1);
        chk("mid_sweep_dmem_addr", 32'(cpu.dmem_addr), 32'h010);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_halt_req", 32'(cpu.halt_req), 32'h0);
        chk("async_rst_owner", 32'(cpu.port_owner), 32'h0);
        chk("async_rst_addrs", 32'({cpu.imem_addr, cpu.dmem_addr, cpu.reg_addr}), 32'h0);
        chk("async_rst_holds", 32'({imem_debug_rdata, dmem_debug_rdata, reg_debug_rdata}), 32'h0);
        chk("async_rst_timeout", 32'(halt_timeout), 32'h0);
        @(posedge clk);
        #1;
        debug_enable = 1'b0; halt_ack = 1'b0; reset_n = 1'b1;
        next_cycle();
        chk("post_rst_idle", 32'({cpu.halt_req, cpu.port_owner}), 32'h0);

        // Directed: sweep with the known values, dmem address moved during RD_IMEM, drop in RD_REG.
        run_session(0, 3, 5 * P, 1'b0, 1'b1);
        // Directed: halt_ack lost in the capture cycle of RD_DMEM, dmem hold must stay 0x99.
        dmem_debug_addr = 12'h010;
        run_session(1, 2, P + RD_LAT, 1'b0, 1'b1);
        chk("ack_drop_keeps_dmem", 32'(dmem_debug_rdata), 32'h99);
        // Directed: timeout with no halt_ack.
        run_session(3, 1, 3, 1'b0, 1'b1);
        chk("timeout_sticky", 32'(halt_timeout), 32'h1);

        // Randomised sessions.
        for (int s = 0; s < 40; s++) begin
            int kind, a, endp;
            kind = $urandom_range(0, 3);
            a    = $urandom_range(1, HT);
            case (kind)
                0, 1:    endp = $urandom_range(0, 12 * P);
                2:       endp = $urandom_range(1, HT - 1);
                default: endp = $urandom_range(0, 3);
            endcase
            run_session(kind, a, endp, 1'(($urandom_range(0, 1))), 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
